// File: rtl/pipe_cmd_sequencer.sv
// PIPE command sequencer: runs LTSSM power-state, rate and receiver-detect
// requests against the PHY with TxElecIdle forcing and the PhyStatus
// completion handshake, and gates the TX datapath outside stable P0.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// RST_WAIT    | PHY still in reset, waiting for PhyStatus to read low
// IDLE        | ready for a command, TxElecIdle follows the LTSSM
// PWR_EI      | TxElecIdle forced high one cycle ahead of a non-P0 PowerDown
// RATE_SETTLE | TxElecIdle held high ELECIDLE_SETTLE cycles before Rate moves
// ISSUE       | new PIPE value on the pins; PhyStatus here is stale, ignored
// PWR_WAIT    | waiting for PhyStatus after a PowerDown change
// RATE_WAIT   | waiting for PhyStatus after a Rate change
// DET_WAIT    | waiting for PhyStatus after TxDetectRx_Loopback
// DONE        | one-cycle completion pulse, back to IDLE next
module pipe_cmd_sequencer #(
  parameter int PHYSTATUS_TIMEOUT = 1024,
  parameter int ELECIDLE_SETTLE   = 8,
  parameter int TMR_W             = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_type,
  input  logic [3:0] req_powerdown,
  input  logic [3:0] req_rate,
  input  logic       tx_elecidle_req,
  output logic       done,
  output logic [1:0] done_status,
  output logic       det_present,
  output logic       phy_ready,
  output logic       tx_gate,
  output logic [3:0] PowerDown,
  output logic [3:0] Rate,
  output logic       TxElecIdle,
  output logic       TxDetectRx_Loopback,
  input  logic       PhyStatus,
  input  logic [2:0] RxStatus
);

  localparam logic [3:0] ST_RST_WAIT    = 4'd0;
  localparam logic [3:0] ST_IDLE        = 4'd1;
  localparam logic [3:0] ST_PWR_EI      = 4'd2;
  localparam logic [3:0] ST_RATE_SETTLE = 4'd3;
  localparam logic [3:0] ST_ISSUE       = 4'd4;
  localparam logic [3:0] ST_PWR_WAIT    = 4'd5;
  localparam logic [3:0] ST_RATE_WAIT   = 4'd6;
  localparam logic [3:0] ST_DET_WAIT    = 4'd7;
  localparam logic [3:0] ST_DONE        = 4'd8;

  localparam logic [1:0] CMD_PWR  = 2'd0;
  localparam logic [1:0] CMD_RATE = 2'd1;
  localparam logic [1:0] CMD_DET  = 2'd2;

  localparam logic [1:0] STS_OK      = 2'd0;
  localparam logic [1:0] STS_TIMEOUT = 2'd1;
  localparam logic [1:0] STS_ILLEGAL = 2'd2;

  localparam logic [3:0] PD_P0 = 4'd0;
  localparam logic [3:0] PD_P1 = 4'd2;

  // which wait state follows the shared ISSUE cycle
  localparam logic [1:0] WK_PWR  = 2'd0;
  localparam logic [1:0] WK_RATE = 2'd1;
  localparam logic [1:0] WK_DET  = 2'd2;

  localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(PHYSTATUS_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(ELECIDLE_SETTLE - 1);

  logic [3:0]       state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [1:0]       wait_kind, wait_kind_nxt;
  logic [3:0]       pd_tgt, pd_tgt_nxt;
  logic [3:0]       rate_tgt, rate_tgt_nxt;

  logic [3:0] powerdown_nxt;
  logic [3:0] rate_nxt;
  logic       elecidle_nxt;
  logic       detrx_nxt;
  logic       done_nxt;
  logic [1:0] status_nxt;
  logic       det_nxt;
  logic       phy_ready_nxt;
  logic       req_ready_nxt;
  logic       tx_gate_nxt;

  // next-state and next-output decode for the whole sequencer
  always_comb begin
    state_nxt     = state;
    tmr_nxt       = tmr;
    wait_kind_nxt = wait_kind;
    pd_tgt_nxt    = pd_tgt;
    rate_tgt_nxt  = rate_tgt;
    powerdown_nxt = PowerDown;
    rate_nxt      = Rate;
    elecidle_nxt  = TxElecIdle;
    detrx_nxt     = TxDetectRx_Loopback;
    done_nxt      = 1'b0;
    status_nxt    = done_status;
    det_nxt       = det_present;
    phy_ready_nxt = phy_ready;

    case (state)
      ST_RST_WAIT: begin
        if (!PhyStatus) begin
          phy_ready_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end
      end

      ST_IDLE: begin
        elecidle_nxt = tx_elecidle_req;
        if (req_valid) begin
          case (req_type)
            CMD_PWR: begin
              if (req_powerdown == PowerDown) begin
                done_nxt   = 1'b1;
                status_nxt = STS_OK;
                state_nxt  = ST_DONE;
              end else if (req_powerdown == PD_P0) begin
                // leaving low power: PowerDown moves at once, idle stays forced
                powerdown_nxt = PD_P0;
                elecidle_nxt  = 1'b1;
                wait_kind_nxt = WK_PWR;
                state_nxt     = ST_ISSUE;
              end else begin
                elecidle_nxt = 1'b1;
                pd_tgt_nxt   = req_powerdown;
                state_nxt    = ST_PWR_EI;
              end
            end
            CMD_RATE: begin
              if (PowerDown != PD_P0) begin
                done_nxt   = 1'b1;
                status_nxt = STS_ILLEGAL;
                state_nxt  = ST_DONE;
              end else begin
                elecidle_nxt = 1'b1;
                rate_tgt_nxt = req_rate;
                tmr_nxt      = '0;
                state_nxt    = ST_RATE_SETTLE;
              end
            end
            CMD_DET: begin
              if (PowerDown != PD_P1) begin
                done_nxt   = 1'b1;
                status_nxt = STS_ILLEGAL;
                state_nxt  = ST_DONE;
              end else begin
                detrx_nxt     = 1'b1;
                wait_kind_nxt = WK_DET;
                state_nxt     = ST_ISSUE;
              end
            end
            default: begin
              done_nxt   = 1'b1;
              status_nxt = STS_ILLEGAL;
              state_nxt  = ST_DONE;
            end
          endcase
        end
      end

      ST_PWR_EI: begin
        powerdown_nxt = pd_tgt;
        wait_kind_nxt = WK_PWR;
        state_nxt     = ST_ISSUE;
      end

      ST_RATE_SETTLE: begin
        if (tmr == SETTLE_LAST) begin
          rate_nxt      = rate_tgt;
          wait_kind_nxt = WK_RATE;
          state_nxt     = ST_ISSUE;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end

      ST_ISSUE: begin
        tmr_nxt = '0;
        case (wait_kind)
          WK_RATE: state_nxt = ST_RATE_WAIT;
          WK_DET:  state_nxt = ST_DET_WAIT;
          default: state_nxt = ST_PWR_WAIT;
        endcase
      end

      ST_PWR_WAIT, ST_RATE_WAIT, ST_DET_WAIT: begin
        tmr_nxt = tmr + 1'b1;
        // PhyStatus is checked first so a pulse on the last cycle still reports OK
        if (PhyStatus) begin
          done_nxt   = 1'b1;
          status_nxt = STS_OK;
          state_nxt  = ST_DONE;
          if (state == ST_DET_WAIT) begin
            det_nxt   = (RxStatus == 3'b011);
            detrx_nxt = 1'b0;
          end
        end else if (tmr == TO_LAST) begin
          done_nxt   = 1'b1;
          status_nxt = STS_TIMEOUT;
          detrx_nxt  = 1'b0;
          state_nxt  = ST_DONE;
        end
      end

      ST_DONE: begin
        elecidle_nxt = tx_elecidle_req;
        state_nxt    = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    req_ready_nxt = (state_nxt == ST_IDLE);
    tx_gate_nxt   = (state_nxt != ST_IDLE) || (powerdown_nxt != PD_P0) || !phy_ready_nxt;
  end

  // register state and every output; reset drops straight back to RST_WAIT
  always_ff @(posedge CLK) begin
    if (reset) begin
      state               <= ST_RST_WAIT;
      tmr                 <= '0;
      wait_kind           <= WK_PWR;
      pd_tgt              <= '0;
      rate_tgt            <= '0;
      PowerDown           <= PD_P1;
      Rate                <= 4'd0;
      TxElecIdle          <= 1'b1;
      TxDetectRx_Loopback <= 1'b0;
      req_ready           <= 1'b0;
      done                <= 1'b0;
      done_status         <= STS_OK;
      det_present         <= 1'b0;
      phy_ready           <= 1'b0;
      tx_gate             <= 1'b1;
    end else begin
      state               <= state_nxt;
      tmr                 <= tmr_nxt;
      wait_kind           <= wait_kind_nxt;
      pd_tgt              <= pd_tgt_nxt;
      rate_tgt            <= rate_tgt_nxt;
      PowerDown           <= powerdown_nxt;
      Rate                <= rate_nxt;
      TxElecIdle          <= elecidle_nxt;
      TxDetectRx_Loopback <= detrx_nxt;
      req_ready           <= req_ready_nxt;
      done                <= done_nxt;
      done_status         <= status_nxt;
      det_present         <= det_nxt;
      phy_ready           <= phy_ready_nxt;
      tx_gate             <= tx_gate_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_cmd_sequencer.sv
// Bench for pipe_cmd_sequencer: directed scenarios followed by random
// commands, each checked cycle by cycle against a per-command timeline model.
module tb_pipe_cmd_sequencer;

  localparam int TO     = 16;
  localparam int SETTLE = 8;

  logic       CLK;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_type;
  logic [3:0] req_powerdown;
  logic [3:0] req_rate;
  logic       tx_elecidle_req;
  logic       done;
  logic [1:0] done_status;
  logic       det_present;
  logic       phy_ready;
  logic       tx_gate;
  logic [3:0] PowerDown;
  logic [3:0] Rate;
  logic       TxElecIdle;
  logic       TxDetectRx_Loopback;
  logic       PhyStatus;
  logic [2:0] RxStatus;

  pipe_cmd_sequencer #(
    .PHYSTATUS_TIMEOUT(TO),
    .ELECIDLE_SETTLE(SETTLE),
    .TMR_W(16)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_type(req_type),
    .req_powerdown(req_powerdown),
    .req_rate(req_rate),
    .tx_elecidle_req(tx_elecidle_req),
    .done(done),
    .done_status(done_status),
    .det_present(det_present),
    .phy_ready(phy_ready),
    .tx_gate(tx_gate),
    .PowerDown(PowerDown),
    .Rate(Rate),
    .TxElecIdle(TxElecIdle),
    .TxDetectRx_Loopback(TxDetectRx_Loopback),
    .PhyStatus(PhyStatus),
    .RxStatus(RxStatus)
  );

  // free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;

  // reference model: architectural state the PIPE pins should show
  logic [3:0] m_pd;
  logic [3:0] m_rate;
  logic       m_ei;
  logic       m_detrx;
  logic       m_det;
  logic       m_ready;
  logic [1:0] m_status;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit busy, input bit dn);
    chk({tag, ".req_ready"},   8'(req_ready),           8'(!busy));
    chk({tag, ".done"},        8'(done),                8'(dn));
    chk({tag, ".done_status"}, 8'(done_status),         8'(m_status));
    chk({tag, ".det_present"}, 8'(det_present),         8'(m_det));
    chk({tag, ".phy_ready"},   8'(phy_ready),           8'(m_ready));
    chk({tag, ".tx_gate"},     8'(tx_gate),             8'(busy || (m_pd != 4'd0) || !m_ready));
    chk({tag, ".PowerDown"},   8'(PowerDown),           8'(m_pd));
    chk({tag, ".Rate"},        8'(Rate),                8'(m_rate));
    chk({tag, ".TxElecIdle"},  8'(TxElecIdle),          8'(m_ei));
    chk({tag, ".TxDetectRx"},  8'(TxDetectRx_Loopback), 8'(m_detrx));
  endtask

  task automatic m_reset();
    m_pd     = 4'd2;
    m_rate   = 4'd0;
    m_ei     = 1'b1;
    m_detrx  = 1'b0;
    m_det    = 1'b0;
    m_ready  = 1'b0;
    m_status = 2'd0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      tx_elecidle_req = 1'($urandom_range(0, 1));
      PhyStatus       = 1'($urandom_range(0, 1));
      tick();
      m_ei = tx_elecidle_req;
      chk_all("idle", 1'b0, 1'b0);
    end
  endtask

  // dl: wait-cycle index carrying the PhyStatus pulse (>= TO means none)
  // abort_at: wait-cycle index at which reset is asserted (-1 = never)
  task automatic run_cmd(input int t, input int pd, input int rt, input int dl,
                         input int rx, input int abort_at);
    logic ei_in;
    bit   illegal;
    bit   ok;
    int   w;
    ei_in   = 1'($urandom_range(0, 1));
    illegal = (t == 3) || (t == 1 && m_pd != 4'd0) || (t == 2 && m_pd != 4'd2);

    tx_elecidle_req = ei_in;
    req_valid       = 1'b1;
    req_type        = 2'(t);
    req_powerdown   = 4'(pd);
    req_rate        = 4'(rt);
    PhyStatus       = 1'($urandom_range(0, 1));
    tick();
    req_valid     = 1'b0;
    req_powerdown = 4'($urandom_range(0, 15));
    req_rate      = 4'($urandom_range(0, 15));
    PhyStatus     = 1'($urandom_range(0, 1));

    if (illegal || (t == 0 && 4'(pd) == m_pd)) begin
      m_ei     = ei_in;
      m_status = illegal ? 2'd2 : 2'd0;
      chk_all("imm_done", 1'b1, 1'b1);
      tick();
      chk_all("imm_post", 1'b0, 1'b0);
      return;
    end

    if (t == 0) begin
      m_ei = 1'b1;
      if (pd != 0) begin
        chk_all("pwr_ei", 1'b1, 1'b0);
        PhyStatus = 1'($urandom_range(0, 1));
        tick();
      end
      m_pd = 4'(pd);
    end else if (t == 1) begin
      m_ei = 1'b1;
      for (int s = 0; s < SETTLE; s++) begin
        chk_all("settle", 1'b1, 1'b0);
        PhyStatus = 1'($urandom_range(0, 1));
        tick();
      end
      m_rate = 4'(rt);
    end else begin
      m_ei    = ei_in;
      m_detrx = 1'b1;
    end
    chk_all("issue", 1'b1, 1'b0);
    PhyStatus = 1'($urandom_range(0, 1));
    tick();

    w = 0;
    forever begin
      chk_all("wait", 1'b1, 1'b0);
      if (w == abort_at) begin
        reset     = 1'b1;
        PhyStatus = 1'b0;
        tick();
        m_reset();
        chk_all("rst_mid", 1'b1, 1'b0);
        tick();
        chk_all("rst_mid2", 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        m_ready = 1'b1;
        chk_all("rst_rec", 1'b0, 1'b0);
        return;
      end
      PhyStatus = (w == dl);
      RxStatus  = (w == dl) ? 3'(rx) : 3'($urandom_range(0, 7));
      tick();
      if (w == dl || w == TO - 1) break;
      w++;
    end
    ok = (w == dl);
    if (t == 2) begin
      if (ok) m_det = (rx == 3);
      m_detrx = 1'b0;
    end
    m_status = ok ? 2'd0 : 2'd1;
    chk_all("done", 1'b1, 1'b1);
    PhyStatus = 1'b0;
    tick();
    m_ei = ei_in;
    chk_all("post", 1'b0, 1'b0);
  endtask

  initial begin
    int t;
    int r;
    reset           = 1'b1;
    req_valid       = 1'b0;
    req_type        = 2'd0;
    req_powerdown   = 4'd0;
    req_rate        = 4'd0;
    tx_elecidle_req = 1'b0;
    PhyStatus       = 1'b1;
    RxStatus        = 3'd0;
    m_reset();

    // reset held 3 cycles, PhyStatus high 5 more, then low
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", 1'b1, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("rst_wait", 1'b1, 1'b0);
    end
    PhyStatus = 1'b0;
    tick();
    m_ready = 1'b1;
    chk_all("phy_ready", 1'b0, 1'b0);
    idle_steps(3);

    // P1 -> P0 with pulse 4 cycles after issue, then P0 -> P2
    run_cmd(0, 0, 0, 3, 0, -1);
    idle_steps(2);
    run_cmd(0, 3, 0, 2, 0, -1);
    run_cmd(0, 0, 0, 0, 0, -1);
    // rate 0 -> 1 in P0, then same request in P1 is illegal
    run_cmd(1, 0, 1, 5, 0, -1);
    run_cmd(0, 2, 0, 1, 0, -1);
    run_cmd(1, 0, 1, 5, 0, -1);
    // detect present / absent / timeout
    run_cmd(2, 0, 0, 2, 3, -1);
    run_cmd(2, 0, 0, 4, 0, -1);
    run_cmd(2, 0, 0, 2, 3, -1);
    run_cmd(2, 0, 0, 99, 3, -1);
    // reset during RATE_WAIT
    run_cmd(0, 0, 0, 1, 0, -1);
    run_cmd(1, 0, 7, 99, 0, 3);
    // PhyStatus coinciding with the timeout
    run_cmd(0, 0, 0, 2, 0, -1);
    run_cmd(1, 0, 9, TO - 1, 0, -1);
    // illegal type and no-op power change
    run_cmd(3, 0, 0, 0, 0, -1);
    run_cmd(0, 0, 0, 0, 0, -1);

    for (int n = 0; n < 80; n++) begin
      idle_steps(int'($urandom_range(0, 3)));
      r = int'($urandom_range(0, 9));
      t = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      run_cmd(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, TO + 4)),
              ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 7)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_cmd_sequencer.md
Name: pipe_cmd_sequencer

Overview:
- Sequences PIPE command/status traffic between the LTSSM and the PHY: power-state changes (PowerDown), rate changes (Rate), and receiver detection (TxDetectRx_Loopback).
- Each change runs with the required TxElecIdle forcing and the PhyStatus completion handshake.
- Also tracks PHY reset completion and gates the TX datapath while the PHY is not in a stable P0 state.
- Sits between the LTSSM and the PIPE output port of the PCIe physical layer top.

Parameters:
PHYSTATUS_TIMEOUT, 1024, cycles to wait for a PhyStatus pulse before aborting with TIMEOUT
ELECIDLE_SETTLE, 8, cycles TxElecIdle is held before Rate is driven during a rate change
TMR_W, 16, width of the shared wait/timeout counter

Ports:
CLK  in  1  PIPE-side clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  LTSSM command request
req_ready  out  1  sequencer can accept a command
req_type  in  2  0=power change, 1=rate change, 2=receiver detect, 3=illegal
req_powerdown  in  4  target power state (P0=0, P0s=1, P1=2, P2=3)
req_rate  in  4  target rate code
tx_elecidle_req  in  1  LTSSM-requested TxElecIdle when no sequence is forcing it
done  out  1  one-cycle completion pulse
done_status  out  2  0=OK, 1=TIMEOUT, 2=ILLEGAL; valid with done, held until next done
det_present  out  1  receiver-detect result; updated only by a detect command
phy_ready  out  1  PHY has left reset (PhyStatus seen low)
tx_gate  out  1  1 = TX datapath must not issue data
PowerDown  out  4  PIPE power state
Rate  out  4  PIPE rate
TxElecIdle  out  1  PIPE electrical idle
TxDetectRx_Loopback  out  1  PIPE receiver-detect request
PhyStatus  in  1  PIPE completion / reset-status pulse
RxStatus  in  3  PIPE receiver status

Behaviour:
- Reset values: PowerDown=2 (P1), Rate=0, TxElecIdle=1, TxDetectRx_Loopback=0, req_ready=0, done=0, done_status=0, det_present=0, phy_ready=0, tx_gate=1. State is RST_WAIT.
- Reset asserted mid-sequence: abort immediately to the reset values; no done pulse.
- RST_WAIT: leave when PhyStatus is sampled 0. Then set phy_ready=1 (it stays 1 until reset) and go to IDLE. No timeout in this state.
- IDLE:
  - req_ready=1. A command is accepted on the cycle req_valid && req_ready.
  - TxElecIdle follows tx_elecidle_req, registered (1-cycle latency).
  - PhyStatus is ignored.
- After acceptance, req_ready=0 until the cycle after done.
- Power change (req_type=0):
  - Target equals current PowerDown: DONE next cycle with OK and no PIPE activity.
  - Target is not P0: cycle+1 TxElecIdle=1; cycle+2 PowerDown=target; enter PWR_WAIT.
  - Target is P0: cycle+1 PowerDown=0, TxElecIdle held 1; enter PWR_WAIT.
- Rate change (req_type=1):
  - Illegal unless PowerDown=0: DONE with ILLEGAL next cycle.
  - Otherwise TxElecIdle=1 for ELECIDLE_SETTLE cycles, then Rate=req_rate for one issue cycle, then RATE_WAIT.
  - Target equal to current Rate still runs the full sequence.
- Detect (req_type=2):
  - Illegal unless PowerDown=2: ILLEGAL.
  - Otherwise TxDetectRx_Loopback=1 next cycle, then DET_WAIT.
  - On the PhyStatus=1 cycle: det_present = (RxStatus==3'b011). TxDetectRx_Loopback=0 the following cycle.
- req_type=3: DONE with ILLEGAL next cycle.
- Wait states (PWR_WAIT, RATE_WAIT, DET_WAIT):
  - The counter clears on entry and increments each cycle.
  - Only PhyStatus=1 sampled from the first wait cycle onward completes the wait. PhyStatus already high on the issue cycle is ignored.
  - PhyStatus=1 goes to DONE with OK.
  - Counter reaching PHYSTATUS_TIMEOUT-1 without PhyStatus goes to DONE with TIMEOUT. PowerDown/Rate keep the new value, TxDetectRx_Loopback drops, det_present is unchanged.
  - PhyStatus and timeout on the same cycle: OK wins.
- DONE: done=1 for one cycle, done_status updated, then IDLE. TxElecIdle resumes tracking tx_elecidle_req.
- tx_gate = 1 when state != IDLE or PowerDown != 0 or !phy_ready; registered.

Test Plan:
- Reset held 3 cycles with PhyStatus=1 for 5 more cycles, then 0 -> phy_ready rises one cycle after the first PhyStatus=0 sample; PowerDown=2, TxElecIdle=1, tx_gate=1 throughout.
- Power P1->P0 with PhyStatus pulse 4 cycles after issue -> PowerDown=0, done with status 0 one cycle after the pulse, tx_gate=0 afterwards. Then P0->P2 -> TxElecIdle=1 exactly one cycle before PowerDown=3.
- Rate change 0->1 in P0 with ELECIDLE_SETTLE=8 -> TxElecIdle=1 for 8 cycles before Rate=1; PhyStatus pulse gives done status 0. The same request in P1 gives ILLEGAL with Rate unchanged.
- Detect in P1 with RxStatus=3'b011 on the PhyStatus cycle -> det_present=1, status 0. Repeat with RxStatus=0 -> det_present=0. TxDetectRx_Loopback deasserts the cycle after the pulse.
- Detect with no PhyStatus and PHYSTATUS_TIMEOUT=16 -> done after 16 wait cycles with status 1, TxDetectRx_Loopback=0, det_present unchanged.
- Rate change with reset asserted during RATE_WAIT, and a separate run with PhyStatus and timeout coinciding -> reset gives all outputs at reset values and no done pulse; coincidence gives done with status 0.
